// File: rtl/train_xing_ctrl_n_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : train_xing_ctrl_n_pkg
//  Description : Shared state encodings for the N-track level-crossing controller.
//  Revision    : 1.0  initial release
// ============================================================================
package train_xing_ctrl_n_pkg;

    // The encoding doubles as the external status code.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BAR_DN = 2'b01,
        ST_GRANT  = 2'b10,
        ST_CLEAR  = 2'b11
    } xing_state_t;

endpackage
`default_nettype wire

// File: rtl/train_xing_ctrl_n_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_n
//  Description : Combinational round-robin pick: first set request after ptr.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter_n #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [IDX_W:0] w_sum;

    // Scan from farthest to nearest so the nearest set request wins.
    always_comb begin
        gnt_idx = '0;
        w_sum   = '0;
        for (int i = N; i >= 1; i--) begin
            w_sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(N)) begin
                w_sum = w_sum - (IDX_W+1)'(N);
            end
            if (req[w_sum[IDX_W-1:0]]) begin
                gnt_idx = w_sum[IDX_W-1:0];
            end
        end
    end

    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/train_xing_ctrl_n.sv
`default_nettype none
// ============================================================================
//  Module      : train_xing_ctrl_n
//  Description : N-track level-crossing controller with round-robin track
//                arbitration, barrier lead time, min-grant, clearance, alarm.
//  Revision    : 1.0  initial release
// ============================================================================
module train_xing_ctrl_n
    import train_xing_ctrl_n_pkg::*;
#(
    parameter int N_TRACKS  = 4,
    parameter int CNT_W     = 16,
    parameter int BAR_CYC   = 8,
    parameter int MIN_GRANT = 16,
    parameter int CLR_CYC   = 4,
    parameter int MAX_GRANT = 1000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_TRACKS-1:0]         V,
    output logic                        B,
    output logic [N_TRACKS-1:0]         T,
    output logic [$clog2(N_TRACKS)-1:0] grant_id,
    output logic [1:0]                  status,
    output logic                        alarm
);

    localparam int c_IDX_W = $clog2(N_TRACKS);

    xing_state_t          r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt,   w_cnt_nxt;
    logic [CNT_W-1:0]     r_age,   w_age_nxt;
    logic [c_IDX_W-1:0]   r_winner, w_winner_nxt;
    logic [c_IDX_W-1:0]   r_ptr,   w_ptr_nxt;
    logic                 r_alarm, w_alarm_nxt;
    logic [c_IDX_W-1:0]   w_pick_idx;
    logic                 w_any;

    rr_arbiter_n #(
        .N     (N_TRACKS),
        .IDX_W (c_IDX_W)
    ) u_rr_arbiter (
        .req     (V),
        .ptr     (r_ptr),
        .gnt_idx (w_pick_idx),
        .any     (w_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_age    <= '0;
            r_winner <= '0;
            r_ptr    <= c_IDX_W'(N_TRACKS-1);
            r_alarm  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_age    <= w_age_nxt;
            r_winner <= w_winner_nxt;
            r_ptr    <= w_ptr_nxt;
            r_alarm  <= w_alarm_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_age_nxt    = r_age;
        w_winner_nxt = r_winner;
        w_ptr_nxt    = r_ptr;
        w_alarm_nxt  = r_alarm;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_winner_nxt = w_pick_idx;
                    w_cnt_nxt    = CNT_W'(BAR_CYC-1);
                    w_state_nxt  = ST_BAR_DN;
                end
            end
            ST_BAR_DN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_GRANT;
                    w_cnt_nxt   = CNT_W'(MIN_GRANT-1);
                    w_age_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_GRANT: begin
                w_cnt_nxt = (r_cnt == '0) ? r_cnt : r_cnt - CNT_W'(1);
                w_age_nxt = (r_age == '1) ? r_age : r_age + CNT_W'(1);
                if (r_age == CNT_W'(MAX_GRANT-1) && V[r_winner]) begin
                    w_alarm_nxt = 1'b1;
                end
                if (r_cnt == '0 && !V[r_winner]) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = CNT_W'(CLR_CYC-1);
                    w_ptr_nxt   = r_winner;
                end
            end
            ST_CLEAR: begin
                if (r_cnt == '0) begin
                    // Pending traffic skips IDLE so the barrier never lifts between trains.
                    if (w_any) begin
                        w_winner_nxt = w_pick_idx;
                        w_state_nxt  = ST_GRANT;
                        w_cnt_nxt    = CNT_W'(MIN_GRANT-1);
                        w_age_nxt    = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign B        = (r_state != ST_IDLE);
    assign T        = (r_state == ST_GRANT) ? (N_TRACKS'(1) << r_winner) : '0;
    assign grant_id = r_winner;
    assign status   = r_state;
    assign alarm    = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_train_xing_ctrl_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_train_xing_ctrl_n
//  Description : Randomised bench for train_xing_ctrl_n against a phase/timer model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_train_xing_ctrl_n;

    localparam int c_N    = 4;
    localparam int c_BAR  = 3;
    localparam int c_MING = 4;
    localparam int c_CLR  = 2;
    localparam int c_MAXG = 20;

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    logic [c_N-1:0] V     = '0;
    logic           B;
    logic [c_N-1:0] T;
    logic [1:0]     grant_id;
    logic [1:0]     status;
    logic           alarm;

    train_xing_ctrl_n #(
        .N_TRACKS  (c_N),
        .CNT_W     (16),
        .BAR_CYC   (c_BAR),
        .MIN_GRANT (c_MING),
        .CLR_CYC   (c_CLR),
        .MAX_GRANT (c_MAXG)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .V        (V),
        .B        (B),
        .T        (T),
        .grant_id (grant_id),
        .status   (status),
        .alarm    (alarm)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: phase 0 idle, 1 barrier lowering, 2 track green, 3 all-red; m_t = cycles spent in phase.
    int       m_phase;
    int       m_t;
    int       m_win;
    int       m_ptr;
    bit       m_alarm;
    logic [c_N-1:0] prev_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [c_N-1:0] v, input int ptr);
        for (int i = 1; i <= c_N; i++) begin
            if (v[(ptr + i) % c_N]) return (ptr + i) % c_N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_t     = 0;
        m_win   = 0;
        m_ptr   = c_N - 1;
        m_alarm = 1'b0;
        prev_t  = '0;
    endtask

    task automatic model_step(input logic [c_N-1:0] v);
        case (m_phase)
            0: if (v != 0) begin
                m_win = rr_pick(v, m_ptr); m_phase = 1; m_t = 0;
            end
            1: if (m_t == c_BAR - 1) begin
                m_phase = 2; m_t = 0;
            end else m_t++;
            2: begin
                if (m_t == c_MAXG - 1 && v[m_win]) m_alarm = 1'b1;
                if (m_t >= c_MING - 1 && !v[m_win]) begin
                    m_phase = 3; m_ptr = m_win; m_t = 0;
                end else m_t++;
            end
            default: if (m_t == c_CLR - 1) begin
                if (v != 0) begin
                    m_win = rr_pick(v, m_ptr); m_phase = 2; m_t = 0;
                end else begin
                    m_phase = 0; m_t = 0;
                end
            end else m_t++;
        endcase
    endtask

    task automatic check_outputs();
        logic [c_N-1:0] exp_t;
        exp_t = (m_phase == 2) ? c_N'(1 << m_win) : '0;
        chk("B",        32'(B),        32'(m_phase != 0));
        chk("T",        32'(T),        32'(exp_t));
        chk("grant_id", 32'(grant_id), 32'(m_win));
        chk("status",   32'(status),   32'(m_phase));
        chk("alarm",    32'(alarm),    32'(m_alarm));
        chk("t_onehot0", 32'($onehot0(T)), 32'(1));
        chk("t_without_b", 32'((T != 0) && !B), 32'(0));
        chk("t_direct_switch", 32'((prev_t != 0) && (T != 0) && (T != prev_t)), 32'(0));
        prev_t = T;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(V);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic hold(input logic [c_N-1:0] v, input int n);
        V = v;
        repeat (n) cycle();
    endtask

    // Reset pulse placed between edges; outputs must clear before any clock edge.
    task automatic async_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rst_B",        32'(B),        32'(0));
        chk("rst_T",        32'(T),        32'(0));
        chk("rst_status",   32'(status),   32'(0));
        chk("rst_alarm",    32'(alarm),    32'(0));
        chk("rst_grant_id", 32'(grant_id), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        check_outputs();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        reset = 1'b0;

        hold(4'b0001, 5);  hold(4'b0000, 10);
        hold(4'b0101, 40); hold(4'b0000, 10);
        hold(4'b0011, 40); hold(4'b0000, 10);
        hold(4'b0001, 30); hold(4'b0000, 10);
        hold(4'b0001, 1);  hold(4'b0011, 1); hold(4'b0010, 20); hold(4'b0000, 8);
        hold(4'b1000, 5);
        async_reset();

        for (int k = 0; k < 80; k++) begin
            logic [c_N-1:0] v;
            v = ($urandom_range(0, 3) == 0) ? '0 : c_N'($urandom_range(1, 15));
            hold(v, int'($urandom_range(1, 25)));
            if (k == 40) async_reset();
        end
        hold(4'b0000, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
